// File: rtl/conv_window_engine.sv
// conv_window_engine: programmable-kernel frame convolver with 3-stage MAC pipeline; CONV_BORDER_ZERO_EN zeroes border pixels
module conv_window_engine #(
  parameter int IMG_WD = 8,
  parameter int IMG_HT = 8,
  parameter int COORD_BITS = 4,
  parameter int WIN_WD = 3,
  parameter int WIN_HT = 3,
  parameter int PXL_BITS = 12,
  parameter int COEF_BITS = 8,
  parameter int SHIFT_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  input  logic [SHIFT_BITS-1:0] cfg_shift,
  input  logic coef_we,
  input  logic [((WIN_WD*WIN_HT > 1) ? $clog2(WIN_WD*WIN_HT) : 1)-1:0] coef_idx,
  input  logic signed [COEF_BITS-1:0] coef_data,
  output logic rd_en,
  output logic [COORD_BITS-1:0] rd_x,
  output logic [COORD_BITS-1:0] rd_y,
  input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0] rd_data_flat,
  output logic wr_en,
  input  logic wr_ready,
  output logic [COORD_BITS-1:0] wr_x,
  output logic [COORD_BITS-1:0] wr_y,
  output logic signed [PXL_BITS-1:0] wr_data_pxl
);
  localparam int N = WIN_WD*WIN_HT;
  localparam int PB = PXL_BITS + COEF_BITS;
  localparam int ACC = PB + $clog2(N);
  localparam logic signed [ACC-1:0] PMAX = ACC'((1 << (PXL_BITS-1)) - 1);
  localparam logic signed [ACC-1:0] PMIN = ~PMAX;
  localparam logic [COORD_BITS-1:0] XL = COORD_BITS'(IMG_WD-1);
  localparam logic [COORD_BITS-1:0] YL = COORD_BITS'(IMG_HT-1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, nxt;
  logic adv, acc_start, last, v0, v1, bd, b0, b1;
  logic [COORD_BITS-1:0] cx, cy, x0, y0, x1, y1;
  logic [SHIFT_BITS-1:0] sh;
  logic signed [COEF_BITS-1:0] coef [N];
  logic signed [PXL_BITS-1:0] win [N];
  logic signed [PB-1:0] prod [N];
  logic signed [ACC-1:0] sum, shd;
  logic signed [PXL_BITS-1:0] sat;
  assign adv = ~(wr_en & ~wr_ready);
  assign acc_start = start & (state == S_IDLE || state == S_DONE);
  assign last = cx == XL && cy == YL;
  assign rd_x = cx;
  assign rd_y = cy;
`ifdef CONV_BORDER_ZERO_EN
  assign bd = cx < COORD_BITS'(WIN_WD/2) || cx > COORD_BITS'(IMG_WD-1-WIN_WD/2) ||
              cy < COORD_BITS'(WIN_HT/2) || cy > COORD_BITS'(IMG_HT-1-WIN_HT/2);
`else
  assign bd = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // DRAIN ends the cycle the final write is accepted, so done rises right after it
  always_comb
    nxt = acc_start ? S_RUN :
          (state == S_RUN && rd_en && last) ? S_DRAIN :
          (state == S_DRAIN && !v0 && !v1 && (!wr_en || wr_ready)) ? S_DONE : state;
  always_comb begin
    busy = state == S_RUN || state == S_DRAIN;
    done = state == S_DONE;
    rd_en = state == S_RUN && adv;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
      sh <= '0;
    end else if (acc_start) begin
      cx <= '0;
      cy <= '0;
      sh <= cfg_shift;
    end else if (rd_en) begin
      cx <= cx == XL ? '0 : cx + 1'b1;
      cy <= cx != XL ? cy : cy == YL ? '0 : cy + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) coef[i] <= (i == N/2) ? COEF_BITS'(N-1) : {COEF_BITS{1'b1}};
    end else if (coef_we && (state == S_IDLE || state == S_DONE)) begin
      coef[coef_idx] <= coef_data;
    end
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + ACC'(prod[i]);
    shd = sum >>> sh;
    sat = shd > PMAX ? PMAX[PXL_BITS-1:0] : shd < PMIN ? PMIN[PXL_BITS-1:0] : shd[PXL_BITS-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v0, v1, wr_en, b0, b1} <= '0;
      {x0, y0, x1, y1, wr_x, wr_y} <= '0;
      wr_data_pxl <= '0;
      for (int i = 0; i < N; i++) begin
        win[i] <= '0;
        prod[i] <= '0;
      end
    end else if (adv) begin
      v0 <= rd_en;
      x0 <= cx;
      y0 <= cy;
      b0 <= bd;
      for (int i = 0; i < N; i++) begin
        win[i] <= rd_data_flat[i*PXL_BITS +: PXL_BITS];
        prod[i] <= PB'(win[i]) * PB'(coef[i]);
      end
      v1 <= v0;
      x1 <= x0;
      y1 <= y0;
      b1 <= b0;
      wr_en <= v1;
      wr_x <= x1;
      wr_y <= y1;
      wr_data_pxl <= b1 ? '0 : sat;
    end
endmodule

// File: tb/tb_conv_window_engine.sv
// tb_conv_window_engine: scoreboard bench for conv_window_engine on a 4x4 image (honours CONV_BORDER_ZERO_EN)
module tb_conv_window_engine;
  localparam int W = 4, H = 4, CB = 4, PB = 12, COB = 8, SB = 4, N = 9;
  typedef struct {int x; int y; int d;} exp_t;
  logic clk = 0, rst_n = 1, start = 0, coef_we = 0, wr_ready = 1;
  logic [SB-1:0] cfg_shift = '0;
  logic [3:0] coef_idx = '0;
  logic signed [COB-1:0] coef_data = '0;
  logic busy, done, rd_en, wr_en;
  logic [CB-1:0] rd_x, rd_y, wr_x, wr_y;
  logic [N*PB-1:0] rd_data_flat;
  logic signed [PB-1:0] wr_data_pxl;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, t0 = 0, mode = 0, rmode = 0, shm = 0, nwr = 0;
  int first_wr = -1, done_cyc = -1, ex = 0, ey = 0, hd = 0, hx = 0;
  bit held = 0;
  int mc [N];

  conv_window_engine #(.IMG_WD(W), .IMG_HT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cfg_shift(cfg_shift), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data_flat(rd_data_flat),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data_pxl(wr_data_pxl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    wr_ready = (rmode == 0) || (((cyc - t0) < 8 || (cyc - t0) >= 13) && ((cyc - t0) < 13 || (cyc - t0) % 2 == 0));
  end

  function automatic int px(int m, int x, int y, int i);
    return m == 0 ? 5 : m == 1 ? (i == 4 ? 100 : 0) : m == 2 ? 2047 : m == 3 ? -2048 : x*10 + y*40 + i*7 - 60;
  endfunction

  function automatic int model(int x, int y);
    int a = 0;
    for (int i = 0; i < N; i++) a += mc[i] * px(mode, x, y, i);
    a = a >>> shm;
    a = a > 2047 ? 2047 : a < -2048 ? -2048 : a;
`ifdef CONV_BORDER_ZERO_EN
    if (x < 1 || x > W-2 || y < 1 || y > H-2) a = 0;
`endif
    return a;
  endfunction

  always_comb begin
    rd_data_flat = '0;
    for (int i = 0; i < N; i++) rd_data_flat[i*PB +: PB] = PB'(px(mode, int'(rd_x), int'(rd_y), i));
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (rd_en) begin
      chk("rd_x", int'(rd_x), ex);
      chk("rd_y", int'(rd_y), ey);
      e.x = ex; e.y = ey; e.d = model(ex, ey);
      q.push_back(e);
      ex = ex == W-1 ? 0 : ex + 1;
      if (ex == 0) ey++;
    end
    if (wr_en && held) begin
      chk("hold_data", int'(wr_data_pxl), hd);
      chk("hold_x", int'(wr_x), hx);
    end
    if (wr_en && first_wr < 0) first_wr = cyc - t0;
    if (done && done_cyc < 0 && first_wr >= 0) done_cyc = cyc - t0;
    held = wr_en && !wr_ready;
    hd = int'(wr_data_pxl);
    hx = int'(wr_x);
    if (wr_en && wr_ready) begin
      nwr++;
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = q.pop_front();
        chk("wr_x", int'(wr_x), e.x);
        chk("wr_y", int'(wr_y), e.y);
        chk("wr_data", int'(wr_data_pxl), e.d);
      end
    end
  end

  task automatic start_frame(input int m, input int s, input int r);
    mode = m; shm = s; rmode = r; cfg_shift = SB'(s);
    ex = 0; ey = 0; nwr = 0; first_wr = -1; done_cyc = -1; held = 0;
    start = 1; t0 = cyc;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic finish_frame(input int r);
    int k = 0;
    while (!done && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("done", int'(done), 1);
    chk("nwr", nwr, W*H);
    chk("q_empty", q.size(), 0);
    if (r == 0) begin
      chk("lat_wr", first_wr, 4);
      chk("lat_done", done_cyc, 20);
    end
  endtask

  task automatic wcoef(input int i, input int v);
    coef_we = 1; coef_idx = 4'(i); coef_data = COB'(v);
    @(posedge clk); #1 coef_we = 0;
    mc[i] = v;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mc[i] = i == 4 ? 8 : -1;
    #2 rst_n = 0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_x", int'(wr_x), 0);
    chk("rst_wr_y", int'(wr_y), 0);
    chk("rst_wr_data", int'(wr_data_pxl), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    start_frame(0, 0, 0); finish_frame(0);
    start_frame(1, 0, 0); finish_frame(0);
    start_frame(1, 3, 0); finish_frame(0);
    for (int i = 0; i < N; i++) wcoef(i, 1);
    start_frame(2, 0, 0); finish_frame(0);
    start_frame(3, 0, 0); finish_frame(0);
    start_frame(4, 0, 1); finish_frame(1);
    for (int i = 0; i < N; i++) wcoef(i, i == 4 ? 8 : -1);
    start_frame(1, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    coef_we = 1; coef_idx = 4'd4; coef_data = '0; start = 1;
    @(posedge clk); #1 coef_we = 0; start = 0;
    finish_frame(0);
    wcoef(4, 0);
    start_frame(1, 0, 0); finish_frame(0);
    start_frame(1, 0, 0);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_done", int'(done), 0);
    q.delete();
    for (int i = 0; i < N; i++) mc[i] = i == 4 ? 8 : -1;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    start_frame(1, 0, 0); finish_frame(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
